uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// Shares the single UART transmitter (tx_data/tx_stb/tx_busy) between NUM_REQ byte-stream sources
// (ihex response path, debug/status reporters). Grants are packet-atomic: once a source wins, it owns
// the TX until it sends a byte flagged last. Round-robin fairness between packets; idle-owner timeout.
// PARAMETERS
// NUM_REQ        2     number of requesters, 2..8
// TIMEOUT_CYCLES 1024  owner-idle cycles mid-packet before forced release; 0 disables timeout
// PORTS
// i_clk        in   1          clock
// i_reset      in   1          asynchronous, active-high reset
// i_req_stb    in   NUM_REQ    per-source byte valid; held until acked
// i_req_data   in   8*NUM_REQ  per-source byte, source k at [8k+7:8k]
// i_req_last   in   NUM_REQ    per-source: this byte ends the packet
// o_req_ack    out  NUM_REQ    one-cycle pulse: byte from source k accepted
// o_tx_data    out  8          byte to UART transmitter
// o_tx_stb     out  1          byte valid to UART; held until transfer
// i_tx_busy    in   1          UART busy; transfer = o_tx_stb && !i_tx_busy at a rising edge
// o_owner      out  $clog2(NUM_REQ) (min 1)  current/last grant index
// o_locked     out  1          a packet is in progress (grant held)
// o_timeout    out  1          one-cycle pulse on forced release
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, rr pointer=0, all outputs 0. A byte in flight is dropped.
// - States: IDLE (no owner), GRANT (owner locked, waiting for its byte), SEND (o_tx_stb high).
// - IDLE: if any i_req_stb, winner = first set bit scanning from rr pointer upward, wrapping.
//   Same edge: owner<=winner, latch data/last, o_req_ack[winner]<=1, o_tx_stb<=1, o_locked<=1 -> SEND.
// - GRANT: only owner eligible; on i_req_stb[owner]: latch, ack pulse, o_tx_stb<=1 -> SEND.
//   Other sources' stb ignored (no ack) until release.
// - SEND: on !i_tx_busy: o_tx_stb<=0; latched last=1 -> IDLE, o_locked<=0, rr pointer<=owner+1
//   (mod NUM_REQ); else -> GRANT, idle counter cleared. i_tx_busy high: hold data/stb unchanged.
// - Latency: stb in IDLE/GRANT -> ack and o_tx_stb high next cycle; min 2 cycles per byte.
//   SEND lasts >=1 cycle, so a requester updating data on ack never gets double-accepted.
// - Ack is registered, exactly 1 cycle, never to more than one source, never in SEND.
// - Timeout: in GRANT, counter increments each cycle owner stb low; resets on accept.
//   At count==TIMEOUT_CYCLES: o_timeout pulse, -> IDLE, o_locked<=0, rr pointer<=owner+1.
//   Counter width $clog2(TIMEOUT_CYCLES+1); saturating not needed (release at terminal).
// - Simultaneous: last byte transfers while others request -> those are arbitrated from IDLE
//   next cycle (1 bubble). Owner stb rising on the timeout cycle: timeout wins, no ack.
// - o_owner holds last grant index while IDLE. No byte reordering or loss except on reset/timeout.
// STRUCTURE
// - Package uart_arb_pkg: state enum {IDLE,GRANT,SEND}, MAX_REQ=8.
// - Sub-module rr_pick (combinational): inputs req vector, pointer; outputs winner index + valid.
// - Main module: FSM, data/last latch, ack register, timeout counter, rr pointer.
// TESTING
// 1 Single source 0 sends 3 bytes 0x3A,0x30,0x0A(last), busy=0 -> TX sees same order, 3 acks,
//   o_locked low after 3rd transfer, pointer=1.
// 2 Both request from IDLE, pointer=0; src0 packet 2 bytes, src1 1 byte -> TX 0x11,0x12(src0),
//   then 0x21(src1); no ack to src1 while src0 locked; next contention grants src0 first again.
// 3 i_tx_busy high 20 cycles during SEND -> o_tx_stb/o_tx_data stable, no second ack, transfer on drop.
// 4 TIMEOUT_CYCLES=8: src0 sends 1 non-last byte then idles -> o_timeout pulse exactly 8 cycles
//   after return to GRANT; pending src1 granted next cycle.
// 5 Assert i_reset mid-SEND with o_tx_stb=1 -> all outputs 0 immediately (async), IDLE after release.
// 6 NUM_REQ=4, all four streaming 1-byte packets -> grants 0,1,2,3,0 strictly rotating.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types and constants for the UART TX arbiter.
// Revision : 1.0
// ============================================================================
package uart_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : uart_arb_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request at or above
//            the pointer, wrapping around.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scanning from the far end down lets the closest-to-pointer hit win last.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(i);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-atomic round-robin sharing of one UART transmitter between
//            NUM_REQ byte sources, with owner-idle timeout.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [NUM_REQ-1:0]                   i_req_stb,
    input  logic [8*NUM_REQ-1:0]                 i_req_data,
    input  logic [NUM_REQ-1:0]                   i_req_last,
    output logic [NUM_REQ-1:0]                   o_req_ack,
    output logic [7:0]                           o_tx_data,
    output logic                                 o_tx_stb,
    input  logic                                 i_tx_busy,
    output logic [idx_width(NUM_REQ)-1:0]        o_owner,
    output logic                                 o_locked,
    output logic                                 o_timeout
);

    localparam int c_IDX_W = idx_width(NUM_REQ);
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_TO_EN = (TIMEOUT_CYCLES > 0);
    // The terminal cycle is itself counted as idle, so release on the Nth idle cycle.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t           r_state, w_state;
    logic [c_IDX_W-1:0]   r_ptr, w_ptr;
    logic [c_IDX_W-1:0]   r_owner, w_owner;
    logic [7:0]           r_data, w_data;
    logic                 r_last, w_last;
    logic [NUM_REQ-1:0]   r_ack, w_ack;
    logic                 r_stb, w_stb;
    logic                 r_locked, w_locked;
    logic                 r_timeout, w_timeout;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt;

    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_pick_valid;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic [7:0]           w_sel_data;
    logic                 w_sel_last;
    logic                 w_sel_stb;
    logic [c_IDX_W-1:0]   w_ptr_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req    (i_req_stb),
        .i_ptr    (r_ptr),
        .o_winner (w_pick),
        .o_valid  (w_pick_valid)
    );

    // In IDLE the arbitration winner is the source of interest; otherwise the owner.
    assign w_sel_idx  = (r_state == IDLE) ? w_pick : r_owner;
    assign w_sel_data = i_req_data[{w_sel_idx, 3'b000} +: 8];
    assign w_sel_last = i_req_last[w_sel_idx];
    assign w_sel_stb  = i_req_stb[w_sel_idx];
    assign w_ptr_inc  = (r_owner == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_ack     <= '0;
            r_stb     <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_owner   <= w_owner;
            r_data    <= w_data;
            r_last    <= w_last;
            r_ack     <= w_ack;
            r_stb     <= w_stb;
            r_locked  <= w_locked;
            r_timeout <= w_timeout;
            r_cnt     <= w_cnt;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_owner   = r_owner;
        w_data    = r_data;
        w_last    = r_last;
        w_ack     = '0;
        w_stb     = r_stb;
        w_locked  = r_locked;
        w_timeout = 1'b0;
        w_cnt     = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_owner          = w_pick;
                    w_data           = w_sel_data;
                    w_last           = w_sel_last;
                    w_ack[w_sel_idx] = 1'b1;
                    w_stb            = 1'b1;
                    w_locked         = 1'b1;
                    w_cnt            = '0;
                    w_state          = SEND;
                end
            end
            GRANT: begin
                // Timeout takes priority over an owner byte arriving on the same cycle.
                if (c_TO_EN && (r_cnt == c_CNT_LAST)) begin
                    w_timeout = 1'b1;
                    w_locked  = 1'b0;
                    w_ptr     = w_ptr_inc;
                    w_state   = IDLE;
                end else if (w_sel_stb) begin
                    w_data           = w_sel_data;
                    w_last           = w_sel_last;
                    w_ack[w_sel_idx] = 1'b1;
                    w_stb            = 1'b1;
                    w_state          = SEND;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            SEND: begin
                if (!i_tx_busy) begin
                    w_stb = 1'b0;
                    if (r_last) begin
                        w_locked = 1'b0;
                        w_ptr    = w_ptr_inc;
                        w_state  = IDLE;
                    end else begin
                        w_cnt   = '0;
                        w_state = GRANT;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign o_req_ack = r_ack;
    assign o_tx_data = r_data;
    assign o_tx_stb  = r_stb;
    assign o_owner   = r_owner;
    assign o_locked  = r_locked;
    assign o_timeout = r_timeout;

endmodule : uart_tx_arbiter
`default_nettype wire
